// File: rtl/exec_ctrl_if.sv
// exec_ctrl_if: bundle of fetch handshake, regfile read/write and ALU signals around exec_ctrl
//   master : the execute controller (accepts instr, reads regfile, issues ALU ops, writes back)
//   slave  : the surrounding fetch/regfile/ALU environment
interface exec_ctrl_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [63:0] pc;
   logic [4:0]  rf_ra1;
   logic [4:0]  rf_ra2;
   logic [63:0] rf_rd1;
   logic [63:0] rf_rd2;
   logic [2:0]  Alu_op;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [63:0] alu_res;
   logic        alu_zero;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [63:0] rf_wd;
   logic        br_taken;
   logic [63:0] br_target;
   logic        illegal;
   logic        done;
   modport master (
      input  instr_valid, instr, pc, rf_rd1, rf_rd2, alu_res, alu_zero,
      output instr_ready, rf_ra1, rf_ra2, Alu_op, alu_a, alu_b,
             rf_we, rf_wa, rf_wd, br_taken, br_target, illegal, done
   );
   modport slave (
      output instr_valid, instr, pc, rf_rd1, rf_rd2, alu_res, alu_zero,
      input  instr_ready, rf_ra1, rf_ra2, Alu_op, alu_a, alu_b,
             rf_we, rf_wa, rf_wd, br_taken, br_target, illegal, done
   );
endinterface

// File: rtl/exec_ctrl.sv
// exec_ctrl: four-state (IDLE/DECODE/EXEC/WB) execute controller driving the shared ALU
//   clk, rst : clock and synchronous active-high reset
//   bus      : exec_ctrl_if.master (instr handshake, regfile ports, ALU ports, writeback/branch results)
module exec_ctrl (
   input logic         clk,
   input logic         rst,
   exec_ctrl_if.master bus
);
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_XOR  = 3'd4;
   localparam logic [2:0] ALU_SLT  = 3'd5;
   localparam logic [2:0] ALU_ADDI = 3'd6;
   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_instr;
   logic [63:0] r_pc, r_a, r_b, r_res, r_tgt;
   logic [2:0]  r_op, w_op;
   logic        r_zero, r_wr, r_br, r_bne, r_ill;
   logic [6:0]  w_opc, w_f7;
   logic [2:0]  w_f3;
   logic        w_i, w_b, w_legal, w_wb;
   logic [63:0] w_imm_i, w_imm_b;
   assign w_opc   = r_instr[6:0];
   assign w_f3    = r_instr[14:12];
   assign w_f7    = r_instr[31:25];
   assign w_i     = (w_opc == 7'b0010011) && (w_f3 == 3'b000);
   assign w_b     = (w_opc == 7'b1100011) && (w_f3[2:1] == 2'b00);
   assign w_imm_i = {{52{r_instr[31]}}, r_instr[31:20]};
   assign w_imm_b = {{51{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
   always_comb begin
      w_op    = w_i ? ALU_ADDI : w_b ? ALU_SUB : ALU_ADD;
      w_legal = w_i | w_b;
      if (w_opc == 7'b0110011) begin
         w_legal = 1'b1;
         case ({w_f7, w_f3})
            10'b0000000_000: w_op = ALU_ADD;
            10'b0100000_000: w_op = ALU_SUB;
            10'b0000000_111: w_op = ALU_AND;
            10'b0000000_110: w_op = ALU_OR;
            10'b0000000_100: w_op = ALU_XOR;
            10'b0000000_010: w_op = ALU_SLT;
            default:         w_legal = 1'b0;
         endcase
      end
   end
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb
      w_next = r_state == IDLE   ? (bus.instr_valid ? DECODE : IDLE) :
               r_state == DECODE ? EXEC :
               r_state == EXEC   ? WB : IDLE;
   always_ff @(posedge clk)
      if (rst) begin
         r_instr <= '0;
         r_pc    <= '0;
         r_op    <= ALU_ADD;
         r_a     <= '0;
         r_b     <= '0;
         r_tgt   <= '0;
         r_res   <= '0;
         r_zero  <= 1'b0;
         r_wr    <= 1'b0;
         r_br    <= 1'b0;
         r_bne   <= 1'b0;
         r_ill   <= 1'b0;
      end else begin
         if (r_state == IDLE && bus.instr_valid) begin
            r_instr <= bus.instr;
            r_pc    <= bus.pc;
         end
         if (r_state == DECODE) begin
            r_op  <= w_op;
            r_a   <= bus.rf_rd1;
            r_b   <= w_i ? w_imm_i : bus.rf_rd2;
            r_tgt <= r_pc + w_imm_b;
            r_wr  <= w_legal & ~w_b & (r_instr[11:7] != 5'd0);
            r_br  <= w_b;
            r_bne <= w_f3[0];
            r_ill <= ~w_legal;
         end
         if (r_state == EXEC) begin
            r_res  <= bus.alu_res;
            r_zero <= bus.alu_zero;
         end
      end
   // Strobes are also masked by rst so a reset landing on WB emits no pulse
   always_comb begin
      w_wb            = (r_state == WB) && !rst;
      bus.instr_ready = (r_state == IDLE) && !rst;
      bus.done        = w_wb;
      bus.rf_we       = w_wb & r_wr;
      bus.br_taken    = w_wb & r_br & (r_zero ^ r_bne);
      bus.illegal     = w_wb & r_ill;
   end
   assign bus.rf_ra1    = r_instr[19:15];
   assign bus.rf_ra2    = r_instr[24:20];
   assign bus.Alu_op    = r_op;
   assign bus.alu_a     = r_a;
   assign bus.alu_b     = r_b;
   assign bus.rf_wa     = r_instr[11:7];
   assign bus.rf_wd     = r_res;
   assign bus.br_target = r_tgt;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: randomized and directed checks of exec_ctrl against an instruction-level reference model
module tb_exec_ctrl;
   localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3,
                          A_XOR = 3'd4, A_SLT = 3'd5, A_ADDI = 3'd6;
   typedef struct packed {
      logic        we;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic        tk;
      logic [63:0] tgt;
      logic        ill;
      logic        br;
      logic [2:0]  op;
      logic [63:0] b;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, failures = 0;
   logic [63:0] regs [32];
   logic [63:0] last_wd, last_tgt, last_b;
   logic        last_we, last_tk, last_ill, last_done;
   bit          prev_hold = 1'b0;
   exec_ctrl_if bus();
   exec_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [63:0] alu_f(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         A_ADD, A_ADDI: return a + b;
         A_SUB:         return a - b;
         A_AND:         return a & b;
         A_OR:          return a | b;
         A_XOR:         return a ^ b;
         A_SLT:         return {63'b0, $signed(a) < $signed(b)};
         default:       return '0;
      endcase
   endfunction
   assign bus.rf_rd1   = regs[bus.rf_ra1];
   assign bus.rf_rd2   = regs[bus.rf_ra2];
   assign bus.alu_res  = alu_f(bus.Alu_op, bus.alu_a, bus.alu_b);
   assign bus.alu_zero = bus.alu_a == bus.alu_b;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic exp_t model(input logic [31:0] ins, input logic [63:0] p, input logic [63:0] x1,
                                  input logic [63:0] x2);
      exp_t        e;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [11:0] i12;
      logic [12:0] b13;
      logic [63:0] si, sb;
      opc = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      i12 = ins[31:20];
      b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      si  = 64'($signed(i12));
      sb  = 64'($signed(b13));
      e = '0;
      e.ill = 1'b1;
      e.wa  = ins[11:7];
      e.b   = x2;
      if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin e.ill = 0; e.op = A_ADD; e.wd = x1 + x2; end
      else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin e.ill = 0; e.op = A_SUB; e.wd = x1 - x2; end
      else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin e.ill = 0; e.op = A_AND; e.wd = x1 & x2; end
      else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin e.ill = 0; e.op = A_OR;  e.wd = x1 | x2; end
      else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd4) begin e.ill = 0; e.op = A_XOR; e.wd = x1 ^ x2; end
      else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd2) begin
         e.ill = 0; e.op = A_SLT; e.wd = {63'b0, $signed(x1) < $signed(x2)};
      end
      else if (opc == 7'h13 && f3 == 3'd0) begin e.ill = 0; e.op = A_ADDI; e.wd = x1 + si; e.b = si; end
      else if (opc == 7'h63 && f3 == 3'd0) begin e.ill = 0; e.br = 1; e.op = A_SUB; e.tk = x1 == x2; e.tgt = p + sb; end
      else if (opc == 7'h63 && f3 == 3'd1) begin e.ill = 0; e.br = 1; e.op = A_SUB; e.tk = x1 != x2; e.tgt = p + sb; end
      e.we = !e.ill && !e.br && ins[11:7] != 5'd0;
      return e;
   endfunction
   // Entered and left on a falling edge; hold keeps instr_valid high with junk instr while busy
   task automatic issue(input logic [31:0] ins, input logic [63:0] p, input logic [63:0] v1,
                        input logic [63:0] v2, input bit hold);
      exp_t e;
      int   n;
      regs[ins[19:15]] = v1;
      regs[ins[24:20]] = v2;
      regs[0] = '0;
      e = model(ins, p, regs[ins[19:15]], regs[ins[24:20]]);
      bus.instr_valid = 1'b1;
      bus.instr = ins;
      bus.pc = p;
      n = 0;
      while (!bus.instr_ready && n < 16) begin @(negedge clk); n++; end
      if (prev_hold) chk("b2b_wait", 64'(n), 64'd0);
      chk("accept_ready", 64'(bus.instr_ready), 64'd1);
      if (!bus.instr_ready) begin bus.instr_valid = 1'b0; prev_hold = 1'b0; return; end
      prev_hold = hold;
      @(negedge clk);
      chk("dec_ready", 64'(bus.instr_ready), 64'd0);
      chk("dec_ra1", 64'(bus.rf_ra1), 64'(ins[19:15]));
      chk("dec_done", 64'(bus.done), 64'd0);
      bus.instr_valid = hold;
      bus.instr = $urandom;
      bus.pc = {$urandom, $urandom};
      @(negedge clk);
      if (!e.ill) begin
         chk("ex_op", 64'(bus.Alu_op), 64'(e.op));
         chk("ex_a", bus.alu_a, regs[ins[19:15]]);
         chk("ex_b", bus.alu_b, e.b);
      end
      chk("ex_done", 64'(bus.done), 64'd0);
      chk("ex_we", 64'(bus.rf_we), 64'd0);
      last_b = bus.alu_b;
      bus.instr = $urandom;
      @(negedge clk);
      chk("wb_done", 64'(bus.done), 64'd1);
      chk("wb_we", 64'(bus.rf_we), 64'(e.we));
      chk("wb_wa", 64'(bus.rf_wa), 64'(e.wa));
      if (e.we) chk("wb_wd", bus.rf_wd, e.wd);
      chk("wb_taken", 64'(bus.br_taken), 64'(e.tk));
      if (e.br) chk("wb_target", bus.br_target, e.tgt);
      chk("wb_illegal", 64'(bus.illegal), 64'(e.ill));
      chk("wb_ready", 64'(bus.instr_ready), 64'd0);
      last_wd = bus.rf_wd; last_tgt = bus.br_target; last_we = bus.rf_we;
      last_tk = bus.br_taken; last_ill = bus.illegal; last_done = bus.done;
      bus.instr = $urandom;
      @(negedge clk);
      chk("idle_ready", 64'(bus.instr_ready), 64'd1);
      chk("idle_done", 64'(bus.done), 64'd0);
   endtask
   initial begin
      logic [31:0] ins;
      logic [63:0] v1, v2;
      logic [4:0]  rd, rs1, rs2;
      int          k;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      bus.instr_valid = 1'b0;
      bus.instr = '0;
      bus.pc = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(bus.instr_ready), 64'd0);
      chk("rst_op", 64'(bus.Alu_op), 64'(A_ADD));
      chk("rst_a", bus.alu_a, 64'd0);
      chk("rst_b", bus.alu_b, 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_we", 64'(bus.rf_we), 64'd0);
      chk("rst_wd", bus.rf_wd, 64'd0);
      chk("rst_wa", 64'(bus.rf_wa), 64'd0);
      chk("rst_tgt", bus.br_target, 64'd0);
      chk("rst_taken", 64'(bus.br_taken), 64'd0);
      chk("rst_illegal", 64'(bus.illegal), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(bus.instr_ready), 64'd1);
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 64'h0, 64'd5, 64'd7, 1'b0);
      chk("add_wd", last_wd, 64'd12);
      chk("add_we", 64'(last_we), 64'd1);
      issue(enc_i(12'hFFF, 5'd1, 5'd5), 64'h4, 64'd5, 64'd0, 1'b0);
      chk("addi_b", last_b, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_wd", last_wd, 64'd4);
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd4), 64'h8, -64'sd3, 64'd2, 1'b0);
      chk("slt_wd", last_wd, 64'd1);
      issue(enc_b(13'd16, 5'd2, 5'd1, 3'd0), 64'h100, 64'd9, 64'd9, 1'b0);
      chk("beq_taken", 64'(last_tk), 64'd1);
      chk("beq_target", last_tgt, 64'h110);
      chk("beq_we", 64'(last_we), 64'd0);
      issue(enc_b(13'd16, 5'd2, 5'd1, 3'd1), 64'h100, 64'd9, 64'd9, 1'b0);
      chk("bne_taken", 64'(last_tk), 64'd0);
      issue(enc_b(13'h1FFC, 5'd2, 5'd1, 3'd0), 64'h0, 64'd9, 64'd9, 1'b0);
      chk("beq_wrap", last_tgt, 64'hFFFF_FFFF_FFFF_FFFC);
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 64'h0, 64'd5, 64'd7, 1'b0);
      chk("x0_we", 64'(last_we), 64'd0);
      chk("x0_done", 64'(last_done), 64'd1);
      issue(32'h0000_0073, 64'h0, 64'd0, 64'd0, 1'b0);
      chk("ecall_illegal", 64'(last_ill), 64'd1);
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd6), 64'h0, 64'd1, 64'd2, 1'b1);
      issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7), 64'h0, 64'd10, 64'd3, 1'b0);
      chk("b2b_sub_wd", last_wd, 64'd7);
      for (int t = 0; t < 60; t++) begin
         k   = $urandom_range(0, 9);
         rd  = 5'($urandom);
         rs1 = 5'($urandom);
         rs2 = 5'($urandom);
         case (k)
            0: ins = enc_r(7'h00, rs2, rs1, 3'd0, rd);
            1: ins = enc_r(7'h20, rs2, rs1, 3'd0, rd);
            2: ins = enc_r(7'h00, rs2, rs1, 3'd7, rd);
            3: ins = enc_r(7'h00, rs2, rs1, 3'd6, rd);
            4: ins = enc_r(7'h00, rs2, rs1, 3'd4, rd);
            5: ins = enc_r(7'h00, rs2, rs1, 3'd2, rd);
            6: ins = enc_i(12'($urandom), rs1, rd);
            7: ins = enc_b({12'($urandom), 1'b0}, rs2, rs1, 3'd0);
            8: ins = enc_b({12'($urandom), 1'b0}, rs2, rs1, 3'd1);
            default: ins = $urandom;
         endcase
         v1 = $urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
         v2 = $urandom_range(0, 2) == 0 ? v1 : {$urandom, $urandom};
         issue(ins, {$urandom, $urandom}, v1, v2, 1'($urandom));
      end
      bus.instr_valid = 1'b0;
      prev_hold = 1'b0;
      @(negedge clk);
      regs[1] = 64'd5;
      regs[2] = 64'd7;
      bus.instr_valid = 1'b1;
      bus.instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
      chk("mid_rst_ready", 64'(bus.instr_ready), 64'd1);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_exec_a", bus.alu_a, 64'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready_hi", 64'(bus.instr_ready), 64'd0);
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      chk("mid_rst_we", 64'(bus.rf_we), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_release_ready", 64'(bus.instr_ready), 64'd1);
      for (int c = 0; c < 4; c++) begin
         chk("mid_rst_no_done", 64'(bus.done), 64'd0);
         chk("mid_rst_no_we", 64'(bus.rf_we), 64'd0);
         @(negedge clk);
      end
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 64'h0, 64'd5, 64'd7, 1'b0);
      chk("post_mid_rst_wd", last_wd, 64'd12);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
